// File: rtl/sd_cmd_seq_ctrl.sv
// SD host command-path sequencer: builds the 48-bit command frame with a
// bit-serial CRC7, launches it, waits for the end bit and then the response
// under an NCR timeout. Validates R1/R2/R3 responses, reports status and
// payload with a done pulse, and holds busy for an NCC gap before the next
// request.
module sd_cmd_seq_ctrl #(
  parameter int RESP_TIMEOUT = 64,
  parameter int NCC_GAP      = 8
) (
  input  logic         sd_clk,
  input  logic         reset,
  input  logic         cmd_req,
  input  logic [5:0]   cmd_index,
  input  logic [31:0]  cmd_arg,
  input  logic [1:0]   resp_type,
  output logic         cmd_busy,
  output logic         cmd_done_strb,
  output logic [3:0]   status,
  output logic [31:0]  resp_short,
  output logic [127:0] resp_long,
  output logic         snd_cmd_strb,
  output logic [47:0]  cmd_packet,
  output logic         r2_resp_enb,
  input  logic         end_bit_det_strb,
  input  logic         new_resp_packet_strb,
  input  logic         new_r2_packet_strb,
  input  logic [47:0]  resp_packet,
  input  logic [135:0] resp2_packet
);

  typedef enum logic [2:0] {
    IDLE, CRC_CMD, LAUNCH, WAIT_END, WAIT_RESP, CRC_RESP, CHECK, GAP
  } state_t;

  localparam int CRC_BITS = 40;
  localparam int CNT_MAX  = (RESP_TIMEOUT > CRC_BITS) ?
                            ((RESP_TIMEOUT > NCC_GAP) ? RESP_TIMEOUT : NCC_GAP) :
                            ((NCC_GAP > CRC_BITS) ? NCC_GAP : CRC_BITS);
  localparam int CNT_W    = $clog2(CNT_MAX + 1);

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt;
  logic [5:0]         index_q;
  logic [31:0]        arg_q;
  logic [1:0]         type_q;
  logic [39:0]        shift_q;
  logic [6:0]         crc_q;
  logic [6:0]         crc_nxt;
  logic [47:0]        resp48_q;
  logic [135:0]       resp136_q;
  logic               resp_hit;
  logic               crc_last;
  logic               resp_tmo;
  logic               gap_last;
  logic               frame_err;
  logic               idx_err;
  logic               crc_err;
  logic               unused_r2_bits;

  // One CRC7 (x^7 + x^3 + 1) step, data bit entering MSB first.
  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
    logic fb;
    fb = din ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  assign crc_nxt  = crc7_step(crc_q, shift_q[39]);
  // Only the strobe matching the latched response width counts.
  assign resp_hit = (type_q == 2'b10) ? new_r2_packet_strb : new_resp_packet_strb;
  assign crc_last = (cnt == CNT_W'(CRC_BITS - 1));
  assign resp_tmo = (cnt == CNT_W'(RESP_TIMEOUT - 1));
  assign gap_last = (cnt == CNT_W'(NCC_GAP - 1));

  // R2 bits [133:128] (check field) are not reported.
  assign unused_r2_bits = ^resp136_q[133:128];

  assign frame_err = (type_q == 2'b10) ?
                     (resp136_q[135] | resp136_q[134] | ~resp136_q[0]) :
                     (resp48_q[47] | resp48_q[46] | ~resp48_q[0]);
  assign idx_err   = (type_q == 2'b01) && (resp48_q[45:40] != index_q);
  assign crc_err   = (type_q == 2'b01) && (resp48_q[7:1] != crc_q);

  assign cmd_busy     = (state != IDLE);
  assign snd_cmd_strb = (state == LAUNCH);
  assign r2_resp_enb  = cmd_busy && (type_q == 2'b10);

  // State register.
  always_ff @(posedge sd_clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  // Next-state logic; a response strobe takes priority over timeout expiry.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:      if (cmd_req) state_d = CRC_CMD;
      CRC_CMD:   if (crc_last) state_d = LAUNCH;
      LAUNCH:    state_d = WAIT_END;
      WAIT_END:  if (end_bit_det_strb) state_d = (type_q == 2'b00) ? GAP : WAIT_RESP;
      WAIT_RESP: begin
        if (resp_hit)      state_d = (type_q == 2'b01) ? CRC_RESP : CHECK;
        else if (resp_tmo) state_d = GAP;
      end
      CRC_RESP:  if (crc_last) state_d = CHECK;
      CHECK:     state_d = GAP;
      GAP:       if (gap_last) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Datapath: request latch, shared cycle counter, serial CRC, capture and status.
  always_ff @(posedge sd_clk or posedge reset) begin
    if (reset) begin
      cnt           <= '0;
      index_q       <= '0;
      arg_q         <= '0;
      type_q        <= '0;
      shift_q       <= '0;
      crc_q         <= '0;
      resp48_q      <= '0;
      resp136_q     <= '0;
      cmd_packet    <= '1;
      status        <= '0;
      resp_short    <= '0;
      resp_long     <= '0;
      cmd_done_strb <= 1'b0;
    end else begin
      cmd_done_strb <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_req) begin
            index_q <= cmd_index;
            arg_q   <= cmd_arg;
            type_q  <= resp_type;
            shift_q <= {2'b01, cmd_index, cmd_arg};
            crc_q   <= '0;
            cnt     <= '0;
            status  <= '0;
          end
        end
        CRC_CMD: begin
          crc_q   <= crc_nxt;
          shift_q <= {shift_q[38:0], 1'b0};
          cnt     <= cnt + 1'b1;
          if (crc_last) cmd_packet <= {2'b01, index_q, arg_q, crc_nxt, 1'b1};
        end
        WAIT_END: begin
          if (end_bit_det_strb) begin
            cnt <= '0;
            if (type_q == 2'b00) cmd_done_strb <= 1'b1;
          end
        end
        WAIT_RESP: begin
          cnt <= cnt + 1'b1;
          if (resp_hit) begin
            if (type_q == 2'b10) resp136_q <= resp2_packet;
            else                 resp48_q  <= resp_packet;
            shift_q <= resp_packet[47:8];
            crc_q   <= '0;
            cnt     <= '0;
          end else if (resp_tmo) begin
            status[3]     <= 1'b1;
            cmd_done_strb <= 1'b1;
            cnt           <= '0;
          end
        end
        CRC_RESP: begin
          crc_q   <= crc_nxt;
          shift_q <= {shift_q[38:0], 1'b0};
          cnt     <= cnt + 1'b1;
        end
        CHECK: begin
          status <= {1'b0, crc_err, idx_err, frame_err};
          if (type_q == 2'b10) resp_long  <= resp136_q[127:0];
          else                 resp_short <= resp48_q[39:8];
          cmd_done_strb <= 1'b1;
          cnt           <= '0;
        end
        GAP:     cnt <= cnt + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_cmd_seq_ctrl.sv
// Testbench for sd_cmd_seq_ctrl: table of directed command transactions with
// hand-computed frames, statuses and latencies, plus a mid-operation reset.
module tb_sd_cmd_seq_ctrl;

  localparam int RESP_TIMEOUT = 64;
  localparam int NCC_GAP      = 8;

  logic         sd_clk;
  logic         reset;
  logic         cmd_req;
  logic [5:0]   cmd_index;
  logic [31:0]  cmd_arg;
  logic [1:0]   resp_type;
  logic         cmd_busy;
  logic         cmd_done_strb;
  logic [3:0]   status;
  logic [31:0]  resp_short;
  logic [127:0] resp_long;
  logic         snd_cmd_strb;
  logic [47:0]  cmd_packet;
  logic         r2_resp_enb;
  logic         end_bit_det_strb;
  logic         new_resp_packet_strb;
  logic         new_r2_packet_strb;
  logic [47:0]  resp_packet;
  logic [135:0] resp2_packet;

  int checks = 0;
  int errors = 0;
  int snd_seen = 0;
  int done_seen = 0;
  int exp_snd = 0;
  int exp_done = 0;

  typedef struct {
    logic [5:0]   idx;
    logic [31:0]  arg;
    logic [1:0]   rtype;
    int           resp_dly;   // cycle after end strobe carrying the response; 0 = none
    logic [47:0]  r48;
    logic [135:0] r136;
    logic         poke;       // extra cmd_req while waiting for the response
    logic [47:0]  exp_pkt;
    logic [3:0]   exp_st;
    logic [31:0]  exp_short;
    logic [127:0] exp_long;
  } vec_t;

  vec_t vecs[8];

  sd_cmd_seq_ctrl #(.RESP_TIMEOUT(RESP_TIMEOUT), .NCC_GAP(NCC_GAP)) dut (
    .sd_clk               (sd_clk),
    .reset                (reset),
    .cmd_req              (cmd_req),
    .cmd_index            (cmd_index),
    .cmd_arg              (cmd_arg),
    .resp_type            (resp_type),
    .cmd_busy             (cmd_busy),
    .cmd_done_strb        (cmd_done_strb),
    .status               (status),
    .resp_short           (resp_short),
    .resp_long            (resp_long),
    .snd_cmd_strb         (snd_cmd_strb),
    .cmd_packet           (cmd_packet),
    .r2_resp_enb          (r2_resp_enb),
    .end_bit_det_strb     (end_bit_det_strb),
    .new_resp_packet_strb (new_resp_packet_strb),
    .new_r2_packet_strb   (new_r2_packet_strb),
    .resp_packet          (resp_packet),
    .resp2_packet         (resp2_packet)
  );

  initial sd_clk = 1'b0;
  always #5 sd_clk = ~sd_clk;

  // Count every strobe pulse the DUT emits.
  always @(negedge sd_clk) begin
    if (snd_cmd_strb)  snd_seen  <= snd_seen + 1;
    if (cmd_done_strb) done_seen <= done_seen + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge sd_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_txn(input vec_t v);
    int n;
    int k;
    int m;
    int g;
    int exp_m;
    g = 0;
    while (cmd_busy && g < 100) begin tick(); g++; end
    cmd_index = v.idx;
    cmd_arg   = v.arg;
    resp_type = v.rtype;
    cmd_req   = 1'b1;
    tick();
    cmd_req = 1'b0;
    chk("busy_after_accept", 128'(cmd_busy), 128'(1));
    chk("r2_enb_busy", 128'(r2_resp_enb), 128'(v.rtype == 2'b10));
    n = 1;
    while (!snd_cmd_strb && n < 100) begin tick(); n++; end
    chk("snd_latency", 128'(n), 128'(41));
    chk("cmd_packet", 128'(cmd_packet), 128'(v.exp_pkt));
    tick();
    chk("snd_one_cycle", 128'(snd_cmd_strb), 128'(0));
    // Stray response strobes before the end bit must be ignored.
    resp_packet          = v.r48;
    resp2_packet         = v.r136;
    new_resp_packet_strb = 1'b1;
    new_r2_packet_strb   = 1'b1;
    tick();
    new_resp_packet_strb = 1'b0;
    new_r2_packet_strb   = 1'b0;
    tick();
    end_bit_det_strb = 1'b1;
    tick();
    end_bit_det_strb = 1'b0;
    k = 1;
    if (v.rtype != 2'b00 && v.resp_dly != 0) begin
      while (k < v.resp_dly) begin
        if (v.poke) begin
          cmd_req = (k == 2 || k == 3);
          if (k == 2) cmd_index = 6'd55;
        end
        if (k == v.resp_dly - 1) begin
          if (v.rtype == 2'b10) new_resp_packet_strb = 1'b1;
          else                  new_r2_packet_strb   = 1'b1;
        end
        tick();
        new_resp_packet_strb = 1'b0;
        new_r2_packet_strb   = 1'b0;
        cmd_req              = 1'b0;
        k++;
      end
      if (v.rtype == 2'b10) new_r2_packet_strb = 1'b1;
      else                  new_resp_packet_strb = 1'b1;
      tick();
      new_resp_packet_strb = 1'b0;
      new_r2_packet_strb   = 1'b0;
      m = 1;
      exp_m = (v.rtype == 2'b01) ? 42 : 2;
    end else begin
      m = 1;
      exp_m = (v.rtype == 2'b00) ? 1 : RESP_TIMEOUT + 1;
    end
    while (!cmd_done_strb && m < 200) begin tick(); m++; end
    chk("done_latency", 128'(m), 128'(exp_m));
    chk("status", 128'(status), 128'(v.exp_st));
    chk("resp_short", 128'(resp_short), 128'(v.exp_short));
    chk("resp_long", resp_long, v.exp_long);
    chk("r2_enb_gap", 128'(r2_resp_enb), 128'(v.rtype == 2'b10));
    exp_snd++;
    exp_done++;
    g = 0;
    while (cmd_busy && g < 50) begin tick(); g++; end
    chk("gap_len", 128'(g), 128'(NCC_GAP));
    chk("r2_enb_idle", 128'(r2_resp_enb), 128'(0));
    chk("snd_count", 128'(snd_seen), 128'(exp_snd));
    chk("done_count", 128'(done_seen), 128'(exp_done));
    if (v.poke) begin
      repeat (5) tick();
      chk("req_not_queued", 128'(cmd_busy), 128'(0));
      chk("packet_held", 128'(cmd_packet), 128'(v.exp_pkt));
    end
  endtask

  initial begin
    vecs[0] = '{6'd0,  32'h0, 2'b00, 0,  48'h0, 136'h0, 1'b0,
                48'h40_0000_0000_95, 4'b0000, 32'h0, 128'h0};
    vecs[1] = '{6'd8,  32'h1AA, 2'b01, 5, 48'h08_0000_01AA_13, 136'h0, 1'b0,
                48'h48_0000_01AA_87, 4'b0000, 32'h0000_01AA, 128'h0};
    vecs[2] = '{6'd8,  32'h1AA, 2'b01, 5, 48'h09_0000_01AA_13, 136'h0, 1'b0,
                48'h48_0000_01AA_87, 4'b0110, 32'h0000_01AA, 128'h0};
    vecs[3] = '{6'd8,  32'h1AA, 2'b01, 5, 48'h08_0000_01AB_13, 136'h0, 1'b0,
                48'h48_0000_01AA_87, 4'b0100, 32'h0000_01AB, 128'h0};
    vecs[4] = '{6'd17, 32'h0, 2'b01, 0, 48'h0, 136'h0, 1'b0,
                48'h51_0000_0000_55, 4'b1000, 32'h0000_01AB, 128'h0};
    vecs[5] = '{6'd2,  32'h0, 2'b10, 5, 48'h0,
                136'h3F_11223344_55667788_99AABBCC_DDEEFF00, 1'b0,
                48'h42_0000_0000_4D, 4'b0001, 32'h0000_01AB,
                128'h11223344_55667788_99AABBCC_DDEEFF00};
    // Response strobe lands in the same cycle the timeout would expire.
    vecs[6] = '{6'd8,  32'h1AA, 2'b11, RESP_TIMEOUT, 48'h3F_00FF_8000_FF, 136'h0, 1'b0,
                48'h48_0000_01AA_87, 4'b0000, 32'h00FF_8000,
                128'h11223344_55667788_99AABBCC_DDEEFF00};
    vecs[7] = '{6'd8,  32'h1AA, 2'b11, 10, 48'h3F_1234_5678_FF, 136'h0, 1'b1,
                48'h48_0000_01AA_87, 4'b0000, 32'h1234_5678,
                128'h11223344_55667788_99AABBCC_DDEEFF00};

    reset                = 1'b1;
    cmd_req              = 1'b0;
    cmd_index            = '0;
    cmd_arg              = '0;
    resp_type            = '0;
    end_bit_det_strb     = 1'b0;
    new_resp_packet_strb = 1'b0;
    new_r2_packet_strb   = 1'b0;
    resp_packet          = '0;
    resp2_packet         = '0;
    tick();
    tick();
    chk("rst_busy", 128'(cmd_busy), 128'(0));
    chk("rst_packet", 128'(cmd_packet), 128'(48'hFFFF_FFFF_FFFF));
    chk("rst_status", 128'(status), 128'(0));
    chk("rst_short", 128'(resp_short), 128'(0));
    chk("rst_long", resp_long, 128'(0));
    chk("rst_strobes", 128'({snd_cmd_strb, cmd_done_strb, r2_resp_enb}), 128'(0));
    reset = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) run_txn(vecs[i]);

    // Reset in the middle of CMD CRC generation.
    cmd_index = 6'd17;
    cmd_arg   = 32'h0;
    resp_type = 2'b01;
    cmd_req   = 1'b1;
    tick();
    cmd_req = 1'b0;
    repeat (10) tick();
    #2 reset = 1'b1;
    #1;
    chk("midrst_busy", 128'(cmd_busy), 128'(0));
    chk("midrst_packet", 128'(cmd_packet), 128'(48'hFFFF_FFFF_FFFF));
    chk("midrst_short", 128'(resp_short), 128'(0));
    chk("midrst_long", resp_long, 128'(0));
    chk("midrst_strobes", 128'({snd_cmd_strb, cmd_done_strb, r2_resp_enb}), 128'(0));
    tick();
    reset = 1'b0;
    repeat (60) tick();
    chk("midrst_no_snd", 128'(snd_seen), 128'(exp_snd));
    chk("midrst_no_done", 128'(done_seen), 128'(exp_done));
    chk("midrst_idle", 128'(cmd_busy), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
